// File: rtl/univ_shift_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : univ_shift_reg                                                  |
// | Desc   : WIDTH-bit universal shift register with autonomous burst engine.|
// |          Optional PARITY output enabled by defining USR_PARITY_EN.       |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIN,
    input  logic             START,
    input  logic [CNT_W-1:0] COUNT,
    output logic [WIDTH-1:0] Q,
    output logic             SOUT,
    output logic             BUSY,
    output logic             DONE
`ifdef USR_PARITY_EN
    ,
    output logic             PARITY
`endif
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] c_hold = 3'b000;
    localparam logic [2:0] c_load = 3'b001;
    localparam logic [2:0] c_shl  = 3'b010;
    localparam logic [2:0] c_shr  = 3'b011;
    localparam logic [2:0] c_rotl = 3'b100;
    localparam logic [2:0] c_rotr = 3'b101;
    localparam logic [2:0] c_ashr = 3'b110;
    localparam logic [2:0] c_clr  = 3'b111;

    localparam logic [CNT_W-1:0] c_width = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_zero  = '0;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_mode;

    logic             w_mode_burstable;
    logic             w_start_acc;
    logic [CNT_W-1:0] w_cnt_clamped;
    logic             w_last_shift;
    logic             w_do_op;
    logic             w_done_set;
    logic [2:0]       w_op_mode;
    logic [WIDTH-1:0] w_q_next;
    logic             w_sout_next;

    assign w_mode_burstable = (MODE >= c_shl) && (MODE <= c_ashr);
    assign w_start_acc      = (r_state == S_IDLE) && START && w_mode_burstable;
    assign w_cnt_clamped    = (COUNT > c_width) ? c_width : COUNT;
    assign w_last_shift     = (r_state == S_RUN) && EN && (r_cnt == c_one);
    // The accepting edge only captures the burst; shifting starts next edge.
    assign w_do_op          = EN && (((r_state == S_IDLE) && !w_start_acc) || (r_state == S_RUN));
    assign w_done_set       = (w_start_acc && (w_cnt_clamped == c_zero)) || w_last_shift;

    always_comb begin
        w_op_mode   = (r_state == S_RUN) ? r_mode : MODE;
        w_q_next    = r_q;
        w_sout_next = r_sout;
        case (w_op_mode)
            c_hold: w_q_next = r_q;
            c_load: w_q_next = D;
            c_shl: begin
                w_q_next    = {r_q[WIDTH-2:0], SIN};
                w_sout_next = r_q[WIDTH-1];
            end
            c_shr: begin
                w_q_next    = {SIN, r_q[WIDTH-1:1]};
                w_sout_next = r_q[0];
            end
            c_rotl: begin
                w_q_next    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_sout_next = r_q[WIDTH-1];
            end
            c_rotr: begin
                w_q_next    = {r_q[0], r_q[WIDTH-1:1]};
                w_sout_next = r_q[0];
            end
            c_ashr: begin
                w_q_next    = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                w_sout_next = r_q[0];
            end
            c_clr: begin
                w_q_next    = '0;
                w_sout_next = 1'b0;
            end
            default: w_q_next = r_q;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc && (w_cnt_clamped != c_zero)) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_shift) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Q    = r_q;
        SOUT = r_sout;
        BUSY = (r_state == S_RUN);
        DONE = r_done;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_q    <= '0;
            r_sout <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_mode <= 3'b000;
        end else begin
            r_done <= w_done_set;
            if (w_do_op) begin
                r_q    <= w_q_next;
                r_sout <= w_sout_next;
            end
            if (w_start_acc) begin
                r_mode <= MODE;
                r_cnt  <= w_cnt_clamped;
            end else if ((r_state == S_RUN) && EN) begin
                r_cnt <= r_cnt - c_one;
            end
        end
    end

`ifdef USR_PARITY_EN
    logic r_parity;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_parity <= 1'b0;
        end else if (w_do_op) begin
            r_parity <= ^w_q_next;
        end
    end

    assign PARITY = r_parity;
`endif

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_univ_shift_reg                                               |
// | Desc   : Directed and randomized checks of univ_shift_reg against a      |
// |          cycle-level arithmetic model. Honors USR_PARITY_EN.             |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_univ_shift_reg;

    localparam int W = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [2:0]    mode = 3'b000;
    logic [W-1:0]  d = '0;
    logic          sin = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] count = '0;
    logic [W-1:0]  q;
    logic          sout, busy, done;
`ifdef USR_PARITY_EN
    logic          parity;
`endif

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state
    int   m_q = 0;
    logic m_sout = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    int   m_cnt = 0;
    int   m_mode = 0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .CLK   (clk),
        .RESET (rst),
        .EN    (en),
        .MODE  (mode),
        .D     (d),
        .SIN   (sin),
        .START (start),
        .COUNT (count),
        .Q     (q),
        .SOUT  (sout),
        .BUSY  (busy),
        .DONE  (done)
`ifdef USR_PARITY_EN
        ,
        .PARITY(parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_apply(input int op);
        int mask, msb, lsb;
        mask = (1 << W) - 1;
        msb  = (m_q >> (W - 1)) & 1;
        lsb  = m_q & 1;
        case (op)
            1: m_q = int'(d);
            2: begin m_sout = msb[0]; m_q = ((m_q << 1) | int'(sin)) & mask; end
            3: begin m_sout = lsb[0]; m_q = (m_q >> 1) | (int'(sin) << (W - 1)); end
            4: begin m_sout = msb[0]; m_q = ((m_q << 1) | msb) & mask; end
            5: begin m_sout = lsb[0]; m_q = (m_q >> 1) | (lsb << (W - 1)); end
            6: begin m_sout = lsb[0]; m_q = (m_q >> 1) | (msb << (W - 1)); end
            7: begin m_sout = 1'b0; m_q = 0; end
            default: ;
        endcase
    endtask

    task automatic model_step();
        int c;
        if (rst) begin
            m_q = 0; m_sout = 0; m_busy = 0; m_done = 0; m_cnt = 0; m_mode = 0;
        end else if (!m_busy) begin
            m_done = 0;
            if (start && mode >= 3'd2 && mode <= 3'd6) begin
                c = (int'(count) > W) ? W : int'(count);
                m_mode = int'(mode);
                if (c == 0) m_done = 1;
                else begin m_busy = 1; m_cnt = c; end
            end else if (en) begin
                model_apply(int'(mode));
            end
        end else begin
            m_done = 0;
            if (en) begin
                model_apply(m_mode);
                m_cnt--;
                if (m_cnt == 0) begin m_busy = 0; m_done = 1; end
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic e, input logic [2:0] m, input logic [W-1:0] dd,
                          input logic s, input logic st, input logic [CW-1:0] c);
        en = e; mode = m; d = dd; sin = s; start = st; count = c;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b1, 3'b001, 8'hFF, 1'b1, 1'b1, 4'd3);
        cycle();
        cycle();
        n_checks++;
        if ({q, sout, busy, done} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got Q=%h SOUT=%b BUSY=%b DONE=%b, want Q=00 SOUT=0 BUSY=0 DONE=0", q, sout, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_step();
        set_in(1'b1, 3'b001, 8'hA5, 1'b0, 1'b0, 4'd0); cycle();
        set_in(1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 4'd0); cycle();
        n_checks++;
        if ({q, sout} !== {8'h4B, 1'b1}) begin
            n_fail++; $display("FAIL shl: got Q=%h SOUT=%b, want Q=4b SOUT=1", q, sout);
        end
        en = 1'b0; mode = 3'b111; cycle(); cycle();
        n_checks++;
        if ({q, sout} !== {8'h4B, 1'b1}) begin
            n_fail++; $display("FAIL en_hold: got Q=%h SOUT=%b, want Q=4b SOUT=1", q, sout);
        end
        set_in(1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 4'd0); cycle();
        mode = 3'b101; cycle();
        n_checks++;
        if ({q, sout} !== {8'hC0, 1'b1}) begin
            n_fail++; $display("FAIL rotr: got Q=%h SOUT=%b, want Q=c0 SOUT=1", q, sout);
        end
        set_in(1'b1, 3'b001, 8'h80, 1'b0, 1'b0, 4'd0); cycle();
        mode = 3'b110; cycle(); cycle();
        n_checks++;
        if ({q, sout} !== {8'hE0, 1'b0}) begin
            n_fail++; $display("FAIL ashr: got Q=%h SOUT=%b, want Q=e0 SOUT=0", q, sout);
        end
        mode = 3'b111; cycle();
        n_checks++;
        if ({q, sout} !== {8'h00, 1'b0}) begin
            n_fail++; $display("FAIL clr: got Q=%h SOUT=%b, want Q=00 SOUT=0", q, sout);
        end
    endtask

    // Runs an SHL x3 burst on 8'h0F; stall_at >= 0 drops EN for one cycle at that RUN cycle.
    task automatic test_burst(input int stall_at, input int want_busy);
        int busy_cycles;
        set_in(1'b1, 3'b001, 8'h0F, 1'b0, 1'b0, 4'd0); cycle();
        set_in(1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 4'd3); cycle();
        start = 1'b0; mode = 3'b000;
        busy_cycles = busy ? 1 : 0;
        for (int i = 0; i < 20 && busy; i++) begin
            en = (i == stall_at) ? 1'b0 : 1'b1;
            cycle();
            if (busy) busy_cycles++;
        end
        en = 1'b1;
        n_checks++;
        if ({q, done, busy} !== {8'h78, 1'b1, 1'b0} || busy_cycles != want_busy) begin
            n_fail++;
            $display("FAIL burst_shl(stall=%0d): got Q=%h DONE=%b BUSY=%b busy_cycles=%0d, want Q=78 DONE=1 BUSY=0 busy_cycles=%0d",
                     stall_at, q, done, busy, busy_cycles, want_busy);
        end
        cycle();
        n_checks++;
        if ({q, done} !== {8'h78, 1'b0}) begin
            n_fail++; $display("FAIL done_pulse: got Q=%h DONE=%b, want Q=78 DONE=0", q, done);
        end
    endtask

    task automatic test_count_zero();
        set_in(1'b1, 3'b001, 8'h55, 1'b0, 1'b0, 4'd0); cycle();
        set_in(1'b1, 3'b011, 8'h00, 1'b1, 1'b1, 4'd0); cycle();
        n_checks++;
        if ({q, busy, done} !== {8'h55, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL count_zero: got Q=%h BUSY=%b DONE=%b, want Q=55 BUSY=0 DONE=1", q, busy, done);
        end
        set_in(1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0); cycle();
        n_checks++;
        if ({q, busy, done} !== {8'h55, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL count_zero_after: got Q=%h BUSY=%b DONE=%b, want Q=55 BUSY=0 DONE=0", q, busy, done);
        end
    endtask

    task automatic test_clamp_rotl();
        int busy_cycles;
        set_in(1'b1, 3'b001, 8'h96, 1'b0, 1'b0, 4'd0); cycle();
        set_in(1'b1, 3'b100, 8'h00, 1'b0, 1'b1, 4'd15); cycle();
        start = 1'b0; mode = 3'b000;
        busy_cycles = busy ? 1 : 0;
        for (int i = 0; i < 30 && busy; i++) begin
            cycle();
            if (busy) busy_cycles++;
        end
        n_checks++;
        if ({q, done} !== {8'h96, 1'b1} || busy_cycles != 8) begin
            n_fail++;
            $display("FAIL clamp_rotl: got Q=%h DONE=%b busy_cycles=%0d, want Q=96 DONE=1 busy_cycles=8", q, done, busy_cycles);
        end
        cycle();
    endtask

    task automatic test_reset_mid_burst();
        int seen_done;
        set_in(1'b1, 3'b001, 8'hF0, 1'b0, 1'b0, 4'd0); cycle();
        set_in(1'b1, 3'b011, 8'h00, 1'b1, 1'b1, 4'd5); cycle();
        start = 1'b0;
        cycle(); cycle();
        n_checks++;
        if ({q, busy} !== {8'hFC, 1'b1}) begin
            n_fail++; $display("FAIL mid_burst: got Q=%h BUSY=%b, want Q=fc BUSY=1", q, busy);
        end
        rst = 1'b1; cycle(); rst = 1'b0;
        n_checks++;
        if ({q, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL reset_abort: got Q=%h BUSY=%b DONE=%b, want Q=00 BUSY=0 DONE=0", q, busy, done);
        end
        mode = 3'b000; seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (done || busy) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) begin
            n_fail++; $display("FAIL reset_no_done: got %0d cycles with DONE/BUSY set, want 0", seen_done);
        end
    endtask

`ifdef USR_PARITY_EN
    task automatic test_parity();
        set_in(1'b1, 3'b001, 8'h07, 1'b0, 1'b0, 4'd0); cycle();
        n_checks++;
        if (parity !== 1'b1) begin
            n_fail++; $display("FAIL parity_07: got PARITY=%b, want 1", parity);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 99) < 2);
            en    = ($urandom_range(0, 99) < 75);
            mode  = 3'($urandom_range(0, 7));
            d     = 8'($urandom);
            sin   = 1'($urandom);
            start = ($urandom_range(0, 99) < 25);
            count = 4'($urandom_range(0, 15));
            cycle();
            n_checks++;
            if ({q, sout, busy, done} !== {m_q[W-1:0], m_sout, m_busy, m_done}) begin
                n_fail++;
                $display("FAIL random[%0d]: got Q=%h SOUT=%b BUSY=%b DONE=%b, want Q=%h SOUT=%b BUSY=%b DONE=%b",
                         i, q, sout, busy, done, m_q[W-1:0], m_sout, m_busy, m_done);
            end
`ifdef USR_PARITY_EN
            n_checks++;
            if (parity !== 1'($countones(m_q) & 1)) begin
                n_fail++; $display("FAIL random_parity[%0d]: got PARITY=%b, want %b", i, parity, 1'($countones(m_q) & 1));
            end
`endif
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_burst(-1, 3);
        test_burst(1, 4);
        test_count_zero();
        test_clamp_rotl();
        test_reset_mid_burst();
`ifdef USR_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
